serial_capture_mon: RTL and testbench
=====================================

Name: serial_capture_mon

Overview:
- Sits between the parallel-to-serial DUT output and the scoreboard.
- Samples the DUT's LSB-first serial stream, rebuilds each 8-bit item, and stores items in order into a packed array of NUM_ITEMS bytes.
- Drives that array straight into the scoreboard's serial-side compare input.
- Flags framing and overflow faults, so a bad stream is reported as a protocol error and not only as data mismatches.

Parameters:
- NUM_ITEMS, 10: number of bytes captured; must be >= 1.
- CNT_W, $clog2(NUM_ITEMS+1): width of the item counter (derived; do not override).

Ports:
- clk  input  1  sampling clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of counters, flags and FSM; array contents kept
- ser_valid  input  1  high while ser_data carries a valid bit
- ser_data  input  1  serial bit, LSB of each byte first
- serial_in_mon  output  [NUM_ITEMS-1:0][7:0]  captured bytes; index 0 is the first byte received
- item_cnt  output  CNT_W  number of bytes committed so far
- done  output  1  high once item_cnt == NUM_ITEMS
- frame_err  output  1  sticky: ser_valid dropped mid-byte
- overflow  output  1  sticky: a byte completed after the array was full

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; bit_cnt=0; shift register=0.
  - item_cnt=0; done=0; frame_err=0; overflow=0.
  - serial_in_mon = all zeros (see Optional Feature for the alternative).
- FSM states IDLE and SHIFT. All sampling happens on the rising clk edge.
- IDLE, ser_valid=1: sample ser_data into bit 0, bit_cnt<=1, go to SHIFT.
- IDLE, ser_valid=0: stay in IDLE.
- SHIFT, ser_valid=1:
  - Place ser_data at bit position bit_cnt.
  - If bit_cnt==7, commit the byte, bit_cnt<=0, go to IDLE.
  - Otherwise bit_cnt++.
- SHIFT, ser_valid=0: set frame_err, discard the partial byte, bit_cnt<=0, go to IDLE. item_cnt is unchanged.
- Back-to-back bytes: ser_valid held high continuously gives a byte every 8 cycles with no gap. The IDLE state samples the first bit of the next byte on the cycle right after a commit.
- Commit, when item_cnt < NUM_ITEMS:
  - serial_in_mon[item_cnt] <= assembled byte, with the bit sampled on the commit edge landing in bit 7.
  - item_cnt++.
  - The byte and the new item_cnt are visible one cycle after the 8th sampled bit (registered, latency 1).
- Commit, when item_cnt == NUM_ITEMS: byte dropped, overflow<=1, array and item_cnt unchanged.
- done is registered and asserts on the same edge where item_cnt reaches NUM_ITEMS.
- clr=1:
  - Same as reset for FSM, bit_cnt, item_cnt, done, frame_err and overflow; serial_in_mon is not cleared.
  - clr has priority over any sample on the same edge; that bit is lost.
- rst asserted mid-byte: the partial byte is lost; after release, capture restarts at index 0.
- Sticky flags clear only on rst or clr.

Optional Feature:
- Macro: SERIAL_MON_XINIT_EN.
- Defined: reset drives every serial_in_mon bit to 'x instead of 0. Slots never written then fail the scoreboard's 4-state !== compare, so missing items are caught.
- Not defined: reset value is 0 (synthesizable, lint-clean).
- clr behaviour is identical in both cases.

Decomposition:
- Package ps_tb_pkg holds:
  - localparam BYTE_W=8
  - typedef logic [BYTE_W-1:0] byte_t
  - typedef enum logic {IDLE, SHIFT} mon_state_e
- One sub-module, serial_deser:
  - Contains the FSM, bit counter and shift register.
  - Outputs byte_valid (1-cycle pulse) and byte_t data, plus a frame_err pulse.
  - serial_capture_mon holds the array, item_cnt, done, and the sticky flags.

Test Plan:
- Send 10 back-to-back bytes 0x00..0x09, LSB first, with ser_valid held high for 80 cycles -> serial_in_mon[i]==i; item_cnt goes 1..10; done rises one cycle after bit 80; no flags.
- Send byte 0xA5, then drop ser_valid after 4 bits of 0x3C, then send a full 0x5A -> items[0]=0xA5, [1]=0x5A; item_cnt=2; frame_err=1.
- With NUM_ITEMS=4, send 5 bytes 0x11,0x22,0x33,0x44,0x55 -> array={0x44,0x33,0x22,0x11}; overflow=1; item_cnt=4; done=1.
- Assert rst asynchronously (between edges) after 3 bits of 0xFF, then send 0x81 -> items[0]==0x81; item_cnt=1; flags 0.
- Capture 2 bytes, pulse clr, then send 0x7E -> items[0]=0x7E, items[1] keeps its old value; item_cnt=1; flags cleared.
- Build with SERIAL_MON_XINIT_EN, apply reset, send 3 of 10 bytes -> items[3..9] are all 'x (scoreboard reports a FAIL); without the macro they are 0x00.

Source files
------------

// File: rtl/serial_capture_mon_pkg.sv
// Shared types for the serial capture monitor.
package ps_tb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {IDLE, SHIFT} mon_state_e;

endpackage

// File: rtl/serial_capture_mon_deser.sv
// serial_deser: rebuilds LSB-first bytes from a valid-qualified bit stream.
// byte_valid, data and frame_err are combinational pulses aligned to the
// sampling edge, so the parent can register the result with one cycle latency.
module serial_deser
  import ps_tb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  ser_valid,
  input  logic  ser_data,
  output logic  byte_valid,
  output byte_t data,
  output logic  frame_err
);

  localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  mon_state_e           state;
  mon_state_e           state_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  byte_t                shreg;

  // State register; clr behaves like a synchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ser_valid) state_next = SHIFT;
      SHIFT:   if (!ser_valid || (bit_cnt == LAST_BIT)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: assembled byte with the current bit in the MSB, plus event pulses.
  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    data       = shreg;
    data[BYTE_W-1] = ser_data;
    if (state == SHIFT) begin
      byte_valid = ser_valid && (bit_cnt == LAST_BIT);
      frame_err  = !ser_valid;
    end
  end

  // Bit counter and shift register; a dropped valid discards the partial byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ser_valid) begin
            shreg   <= BYTE_W'(ser_data);
            bit_cnt <= BIT_CNT_W'(1);
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            shreg[bit_cnt] <= ser_data;
            bit_cnt        <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
          end else begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        default: begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_capture_mon.sv
// serial_capture_mon: captures NUM_ITEMS serial bytes in arrival order and
// flags framing and overflow faults.
// Build option SERIAL_MON_XINIT_EN: reset loads 'x into the capture array so
// never-written slots stand out in a 4-state compare; otherwise reset loads 0.
module serial_capture_mon
  import ps_tb_pkg::*;
#(
  parameter  int unsigned NUM_ITEMS = 10,
  localparam int unsigned CNT_W     = $clog2(NUM_ITEMS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            ser_valid,
  input  logic                            ser_data,
  output logic [NUM_ITEMS-1:0][BYTE_W-1:0] serial_in_mon,
  output logic [CNT_W-1:0]                item_cnt,
  output logic                            done,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_ITEMS);

  logic  byte_valid;
  byte_t byte_data;
  logic  frame_pulse;
  logic  has_room;

  assign has_room = (item_cnt < FULL);

  serial_deser u_deser (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .byte_valid (byte_valid),
    .data       (byte_data),
    .frame_err  (frame_pulse)
  );

  // Capture array: each committed byte lands in the next free slot; clr keeps contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SERIAL_MON_XINIT_EN
      serial_in_mon <= 'x;
`else
      serial_in_mon <= '0;
`endif
    end else if (!clr && byte_valid && has_room) begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        if (CNT_W'(i) == item_cnt) serial_in_mon[i] <= byte_data;
      end
    end
  end

  // Item count, done and sticky fault flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      item_cnt  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      item_cnt  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_pulse) frame_err <= 1'b1;
      if (byte_valid) begin
        if (has_room) begin
          item_cnt <= item_cnt + CNT_W'(1);
          done     <= (item_cnt == FULL - CNT_W'(1));
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_capture_mon.sv
// Self-checking bench for serial_capture_mon: a 10-item instance for the main
// scenarios and a 4-item instance for overflow. Expected bytes are queued as
// they are sent and matched against the array whenever item_cnt advances.
module tb_serial_capture_mon;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic              a_valid = 1'b0;
  logic              a_data  = 1'b0;
  logic [9:0][7:0]   a_mon;
  logic [3:0]        a_cnt;
  logic              a_done, a_ferr, a_ovf;

  logic              b_valid = 1'b0;
  logic              b_data  = 1'b0;
  logic [3:0][7:0]   b_mon;
  logic [2:0]        b_cnt;
  logic              b_done, b_ferr, b_ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [3:0] a_prev = '0;
  logic [2:0] b_prev = '0;

  serial_capture_mon #(.NUM_ITEMS(10)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .ser_valid     (a_valid),
    .ser_data      (a_data),
    .serial_in_mon (a_mon),
    .item_cnt      (a_cnt),
    .done          (a_done),
    .frame_err     (a_ferr),
    .overflow      (a_ovf)
  );

  serial_capture_mon #(.NUM_ITEMS(4)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .ser_valid     (b_valid),
    .ser_data      (b_data),
    .serial_in_mon (b_mon),
    .item_cnt      (b_cnt),
    .done          (b_done),
    .frame_err     (b_ferr),
    .overflow      (b_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for instance A: each count step must reveal the next queued byte.
  always @(negedge clk) begin
    if (a_cnt !== a_prev) begin
      if (a_cnt == a_prev + 4'd1) begin
        chk("a_sb_avail", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) chk("a_sb_item", 32'(a_mon[a_cnt - 4'd1]), 32'(q_a.pop_front()));
      end else if (a_cnt > a_prev) begin
        chk("a_cnt_step", 32'(a_cnt), 32'(a_prev) + 32'd1);
      end
      a_prev = a_cnt;
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (b_cnt !== b_prev) begin
      if (b_cnt == b_prev + 3'd1) begin
        chk("b_sb_avail", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) chk("b_sb_item", 32'(b_mon[b_cnt - 3'd1]), 32'(q_b.pop_front()));
      end else if (b_cnt > b_prev) begin
        chk("b_cnt_step", 32'(b_cnt), 32'(b_prev) + 32'd1);
      end
      b_prev = b_cnt;
    end
  end

  // Drive n bits of b, LSB first; entered and left at posedge+1.
  task automatic send_bits(input int which, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) begin a_valid = 1'b1; a_data = b[i]; end
      else            begin b_valid = 1'b1; b_data = b[i]; end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    send_bits(which, b, 8);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; a_data = 1'b0;
    b_valid = 1'b0; b_data = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_rst();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_cnt",  32'(a_cnt),  32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ferr", 32'(a_ferr), 32'd0);
    chk("rst_ovf",  32'(a_ovf),  32'd0);
    chk("rst_mon0", 32'(a_mon[0]), 32'd0);

    // Ten back-to-back bytes 0..9
    for (int i = 0; i < 9; i++) begin
      q_a.push_back(8'(i));
      send_byte(0, 8'(i));
    end
    chk("b2b_cnt9",  32'(a_cnt),  32'd9);
    chk("b2b_done9", 32'(a_done), 32'd0);
    q_a.push_back(8'd9);
    send_byte(0, 8'd9);
    chk("b2b_cnt10",  32'(a_cnt),  32'd10);
    chk("b2b_done10", 32'(a_done), 32'd1);
    idle(2);
    for (int i = 0; i < 10; i++) chk("b2b_item", 32'(a_mon[i]), 32'(i));
    chk("b2b_ferr", 32'(a_ferr), 32'd0);
    chk("b2b_ovf",  32'(a_ovf),  32'd0);

    // One more byte into a full array
    send_byte(0, 8'hEE);
    idle(2);
    chk("full_ovf",   32'(a_ovf),   32'd1);
    chk("full_cnt",   32'(a_cnt),   32'd10);
    chk("full_mon9",  32'(a_mon[9]), 32'd9);

    // Framing error between two good bytes
    pulse_rst();
    chk("rst_clears_mon", 32'(a_mon[0]), 32'd0);
    chk("rst_clears_ovf", 32'(a_ovf), 32'd0);
    q_a.push_back(8'hA5);
    send_byte(0, 8'hA5);
    send_bits(0, 8'h3C, 4);
    idle(2);
    q_a.push_back(8'h5A);
    send_byte(0, 8'h5A);
    idle(2);
    chk("fr_item0", 32'(a_mon[0]), 32'hA5);
    chk("fr_item1", 32'(a_mon[1]), 32'h5A);
    chk("fr_cnt",   32'(a_cnt),    32'd2);
    chk("fr_ferr",  32'(a_ferr),   32'd1);
    chk("fr_ovf",   32'(a_ovf),    32'd0);

    // clr with valid high: that bit is dropped, array kept, then 0x7E
    clr = 1'b1; a_valid = 1'b1; a_data = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_cnt",  32'(a_cnt),  32'd0);
    chk("clr_ferr", 32'(a_ferr), 32'd0);
    q_a.push_back(8'h7E);
    send_byte(0, 8'h7E);
    idle(2);
    chk("clr_item0", 32'(a_mon[0]), 32'h7E);
    chk("clr_item1", 32'(a_mon[1]), 32'h5A);
    chk("clr_cnt1",  32'(a_cnt),     32'd1);
    chk("clr_flags", 32'({a_ferr, a_ovf, a_done}), 32'd0);

    // Async reset mid-byte, then 0x81
    send_bits(0, 8'hFF, 3);
    pulse_rst();
    idle(1);
    q_a.push_back(8'h81);
    send_byte(0, 8'h81);
    idle(2);
    chk("mid_item0", 32'(a_mon[0]), 32'h81);
    chk("mid_cnt",   32'(a_cnt),    32'd1);
    chk("mid_flags", 32'({a_ferr, a_ovf, a_done}), 32'd0);

    // Partial fill: unwritten slots keep their reset value
    q_a.push_back(8'h10);
    send_byte(0, 8'h10);
    q_a.push_back(8'h20);
    send_byte(0, 8'h20);
    idle(2);
    chk("part_cnt", 32'(a_cnt), 32'd3);
    for (int i = 3; i < 10; i++) chk("unwritten", 32'(a_mon[i]), 32'd0);

    // Overflow on the 4-item instance
    q_b.push_back(8'h11); send_byte(1, 8'h11);
    q_b.push_back(8'h22); send_byte(1, 8'h22);
    q_b.push_back(8'h33); send_byte(1, 8'h33);
    q_b.push_back(8'h44); send_byte(1, 8'h44);
    chk("b_done4", 32'(b_done), 32'd1);
    chk("b_ovf4",  32'(b_ovf),  32'd0);
    send_byte(1, 8'h55);
    idle(2);
    chk("b_array", 32'(b_mon), 32'h44332211);
    chk("b_ovf",   32'(b_ovf),  32'd1);
    chk("b_cnt",   32'(b_cnt),  32'd4);
    chk("b_done",  32'(b_done), 32'd1);
    chk("b_ferr",  32'(b_ferr), 32'd0);

    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
